// File: rtl/image_pkg.sv
`default_nettype none
// ============================================================================
// Module      : image_pkg
// Description : Shared pixel types and default geometry for the image pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package image_pkg;

    localparam int PIXEL_W = 12;
    localparam int LINE_W  = 640;

    typedef logic [PIXEL_W-1:0] pixel_t;

    typedef struct packed {
        logic   edge_flag;
        pixel_t pixel;
    } tagged_pixel_t;

endpackage : image_pkg
`default_nettype wire

// File: rtl/line_delay.sv
`default_nettype none
// ============================================================================
// Module      : line_delay
// Description : One circular line memory with a read-before-write port.
// Revision    : 1.0 - initial release
// ============================================================================
module line_delay #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 13,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o
);

    // No reset on the storage: stale contents are masked downstream.
    logic [WIDTH-1:0] mem_q [DEPTH];

    assign rdata_o = mem_q[addr_i];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule : line_delay
`default_nettype wire

// File: rtl/line_window_buffer.sv
`default_nettype none
// ============================================================================
// Module      : line_window_buffer
// Description : Multi-row line buffer presenting NUM_ROWS vertically aligned taps.
// Revision    : 1.0 - initial release
// ============================================================================
module line_window_buffer
    import image_pkg::*;
#(
    parameter int DATA_WIDTH = PIXEL_W,
    parameter int LINE_WIDTH = LINE_W,
    parameter int NUM_ROWS   = 3,
    parameter int COL_W      = $clog2(LINE_WIDTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           sof,
    input  logic [DATA_WIDTH-1:0]          pixel_in,
    input  logic                           pixel_valid,
    input  logic                           pixel_edge,
    output logic [NUM_ROWS*DATA_WIDTH-1:0] taps_out,
    output logic                           tap_edge,
    output logic                           tap_valid,
    output logic                           window_valid,
    output logic [COL_W-1:0]               col_cnt,
    output logic                           line_done
);

    localparam int                 FILL_W    = $clog2(NUM_ROWS);
    localparam int                 WORD_W    = DATA_WIDTH + 1;
    localparam logic [COL_W-1:0]   LAST_COL  = COL_W'(LINE_WIDTH - 1);
    localparam logic [FILL_W-1:0]  FULL_FILL = FILL_W'(NUM_ROWS - 1);

    typedef struct packed {
        logic                  edge_flag;
        logic [DATA_WIDTH-1:0] pixel;
    } tap_word_t;

    logic                           accept_w;
    logic                           resync_w;
    logic [COL_W-1:0]               addr_w;
    logic [FILL_W-1:0]              fill_cur_w;
    tap_word_t                      line_wr_w [NUM_ROWS-1];
    tap_word_t                      line_rd_w [NUM_ROWS-1];

    logic [COL_W-1:0]               wptr_q,         wptr_d;
    logic [FILL_W-1:0]              fill_q,         fill_d;
    logic [NUM_ROWS*DATA_WIDTH-1:0] taps_q,         taps_d;
    logic                           tap_edge_q,     tap_edge_d;
    logic                           tap_valid_q,    tap_valid_d;
    logic                           window_valid_q, window_valid_d;
    logic [COL_W-1:0]               col_q,          col_d;
    logic                           line_done_q,    line_done_d;

    assign accept_w   = en & pixel_valid;
    assign resync_w   = en & sof;
    // A frame start takes effect for a pixel arriving in the same cycle.
    assign addr_w     = resync_w ? '0 : wptr_q;
    assign fill_cur_w = resync_w ? '0 : fill_q;

    generate
        for (genvar k = 0; k < NUM_ROWS - 1; k++) begin : g_line
            if (k == 0) begin : g_head
                assign line_wr_w[k] = {pixel_edge, pixel_in};
            end else begin : g_cascade
                assign line_wr_w[k] = line_rd_w[k-1];
            end

            line_delay #(
                .DEPTH (LINE_WIDTH),
                .WIDTH (WORD_W),
                .AW    (COL_W)
            ) u_line (
                .clk     (clk),
                .wr_en_i (accept_w),
                .addr_i  (addr_w),
                .wdata_i (line_wr_w[k]),
                .rdata_o (line_rd_w[k])
            );
        end
    endgenerate

    always_comb begin
        wptr_d         = wptr_q;
        fill_d         = fill_q;
        taps_d         = taps_q;
        tap_edge_d     = tap_edge_q;
        col_d          = col_q;
        tap_valid_d    = 1'b0;
        window_valid_d = 1'b0;
        line_done_d    = 1'b0;

        if (resync_w) begin
            wptr_d = '0;
            fill_d = '0;
        end

        if (accept_w) begin
            wptr_d = (addr_w == LAST_COL) ? '0 : addr_w + COL_W'(1);
            if ((addr_w == LAST_COL) && (fill_cur_w != FULL_FILL)) begin
                fill_d = fill_cur_w + FILL_W'(1);
            end
            taps_d[DATA_WIDTH-1:0] = pixel_in;
            for (int k = 1; k < NUM_ROWS; k++) begin
                taps_d[k*DATA_WIDTH +: DATA_WIDTH] = line_rd_w[k-1].pixel;
            end
            tap_edge_d     = line_rd_w[NUM_ROWS-2].edge_flag;
            col_d          = addr_w;
            tap_valid_d    = 1'b1;
            window_valid_d = (fill_cur_w == FULL_FILL);
            line_done_d    = (addr_w == LAST_COL);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q         <= '0;
            fill_q         <= '0;
            taps_q         <= '0;
            tap_edge_q     <= 1'b0;
            tap_valid_q    <= 1'b0;
            window_valid_q <= 1'b0;
            col_q          <= '0;
            line_done_q    <= 1'b0;
        end else begin
            wptr_q         <= wptr_d;
            fill_q         <= fill_d;
            taps_q         <= taps_d;
            tap_edge_q     <= tap_edge_d;
            tap_valid_q    <= tap_valid_d;
            window_valid_q <= window_valid_d;
            col_q          <= col_d;
            line_done_q    <= line_done_d;
        end
    end

    assign taps_out     = taps_q;
    assign tap_edge     = tap_edge_q;
    assign tap_valid    = tap_valid_q;
    assign window_valid = window_valid_q;
    assign col_cnt      = col_q;
    assign line_done    = line_done_q;

endmodule : line_window_buffer
`default_nettype wire
